// File: rtl/dual_port_memory_ctrl.sv
// rtl/dual_port_memory_ctrl.sv - true dual-port word memory with handshake, read latency, collision handling and clear sweep
// Optional feature macro: MEM_PARITY_EN (per-word even parity, a_parity_err/b_parity_err outputs).
// All state changes on the falling edge so the CPU samples results on its next rising edge.
module dual_port_memory_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
`ifdef MEM_PARITY_EN
  output logic                  a_parity_err,
  output logic                  b_parity_err,
`endif
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  busy,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
`ifdef MEM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_addr_q, clr_addr_d;
  logic [MW-1:0]         mem_q [DEPTH];

  logic                  run, clr_we;
  logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [MW-1:0]         a_word, b_word;
  logic [DATA_WIDTH-1:0] a_res_d, b_res_d;
  logic                  collision_d;

  logic [DATA_WIDTH-1:0] a_rd1_q, b_rd1_q;
  logic                  a_rv1_q, b_rv1_q;
  logic                  collision_q;

  // Stored word layout: {parity, data} when parity is enabled, plain data otherwise.
  function automatic logic [MW-1:0] make_word(input logic [DATA_WIDTH-1:0] d);
`ifdef MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign run         = (state_q == ST_RUN);
  assign busy        = (state_q == ST_CLEAR);
  assign a_ready     = run;
  assign b_ready     = run;
  assign collision   = collision_q;

  // Reset is folded in so a request present while reset is high never reaches the RAM.
  assign clr_we      = busy && !reset;
  assign acc_a       = a_valid && run && !reset;
  assign acc_b       = b_valid && run && !reset;
  assign wr_a        = acc_a && a_write;
  assign wr_b        = acc_b && b_write;
  assign same_addr   = (a_addr == b_addr);
  assign collision_d = wr_a && wr_b && same_addr;

  assign a_word = mem_q[a_addr];
  assign b_word = mem_q[b_addr];

  // Result selection: own write-through first, then bypass of the other port's same-address write.
  // On a double write to one address A's data wins, so both ports return it.
  always_comb begin
    a_res_d = a_word[DATA_WIDTH-1:0];
    b_res_d = b_word[DATA_WIDTH-1:0];
    if (wr_a) begin
      a_res_d = a_wdata;
    end else if (wr_b && same_addr) begin
      a_res_d = b_wdata;
    end
    if (wr_a && same_addr) begin
      b_res_d = a_wdata;
    end else if (wr_b) begin
      b_res_d = b_wdata;
    end
  end

  // Clear-sweep FSM next state: one word per edge, leave after writing the last address.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + (ADDR_WIDTH + 1)'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  ;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register; reset restarts the sweep from address 0.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // RAM write port: clear sweep, else accepted writes; B's write is dropped when A hits the same word.
  always_ff @(negedge clock) begin
    if (clr_we) begin
      mem_q[clr_addr_q[ADDR_WIDTH-1:0]] <= make_word('0);
    end else begin
      if (wr_b && !(wr_a && same_addr)) begin
        mem_q[b_addr] <= make_word(b_wdata);
      end
      if (wr_a) begin
        mem_q[a_addr] <= make_word(a_wdata);
      end
    end
  end

  // First output stage: capture results on accept, hold rdata otherwise, strobe rvalid.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      a_rd1_q     <= '0;
      b_rd1_q     <= '0;
      a_rv1_q     <= 1'b0;
      b_rv1_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_rv1_q     <= acc_a;
      b_rv1_q     <= acc_b;
      collision_q <= collision_d;
      if (acc_a) begin
        a_rd1_q <= a_res_d;
      end
      if (acc_b) begin
        b_rd1_q <= b_res_d;
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic a_perr_d, b_perr_d;
  logic a_pe1_q, b_pe1_q;

  // Only words actually read from the array can flag; forwarded write data is known good.
  assign a_perr_d = acc_a && !wr_a && !(wr_b && same_addr) && (^a_word);
  assign b_perr_d = acc_b && !wr_b && !(wr_a && same_addr) && (^b_word);

  // Parity error strobes travel alongside the first-stage rvalid.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      a_pe1_q <= 1'b0;
      b_pe1_q <= 1'b0;
    end else begin
      a_pe1_q <= a_perr_d;
      b_pe1_q <= b_perr_d;
    end
  end
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_rd2_q, b_rd2_q;
    logic                  a_rv2_q, b_rv2_q;

    // Second output stage: pure delay of the first, fully pipelined.
    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        a_rd2_q <= '0;
        b_rd2_q <= '0;
        a_rv2_q <= 1'b0;
        b_rv2_q <= 1'b0;
      end else begin
        a_rv2_q <= a_rv1_q;
        b_rv2_q <= b_rv1_q;
        if (a_rv1_q) begin
          a_rd2_q <= a_rd1_q;
        end
        if (b_rv1_q) begin
          b_rd2_q <= b_rd1_q;
        end
      end
    end

    assign a_rdata  = a_rd2_q;
    assign b_rdata  = b_rd2_q;
    assign a_rvalid = a_rv2_q;
    assign b_rvalid = b_rv2_q;

`ifdef MEM_PARITY_EN
    logic a_pe2_q, b_pe2_q;

    // Delay parity strobes to stay aligned with the second-stage rvalid.
    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        a_pe2_q <= 1'b0;
        b_pe2_q <= 1'b0;
      end else begin
        a_pe2_q <= a_pe1_q;
        b_pe2_q <= b_pe1_q;
      end
    end

    assign a_parity_err = a_pe2_q;
    assign b_parity_err = b_pe2_q;
`endif
  end else begin : g_lat1
    assign a_rdata  = a_rd1_q;
    assign b_rdata  = b_rd1_q;
    assign a_rvalid = a_rv1_q;
    assign b_rvalid = b_rv1_q;
`ifdef MEM_PARITY_EN
    assign a_parity_err = a_pe1_q;
    assign b_parity_err = b_pe1_q;
`endif
  end

endmodule
